// File: rtl/z16_instr_mem_sync.sv
// Purpose : loadable Z16 instruction memory, registered fetch port with valid/ready, word-write load port, fault reporting.
// Latency : fetch response exactly 1 cycle after accept; load write commits at the accepting edge.
// Backpr. : a stalled response (o_instr_valid && !i_instr_ready) holds and blocks new fetch accepts; load mode also blocks accepts.
//
// Ports:
//   i_clk, i_rst_n                      clock, synchronous active-low reset
//   i_fetch_valid/o_fetch_ready/i_fetch_addr   fetch request (byte address)
//   o_instr_valid/i_instr_ready/o_instr/o_fault response (o_fault qualified by o_instr_valid)
//   i_load_en/i_load_we/i_load_addr/i_load_data load port; o_load_err pulses on a rejected write
module z16_instr_mem_sync #(
   parameter int                DATA_W    = 16,
   parameter int                ADDR_W    = 16,
   parameter int                DEPTH     = 1024,
   parameter logic [DATA_W-1:0] NOP_INSTR = 16'h0000
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_fetch_valid,
   output logic              o_fetch_ready,
   input  logic [ADDR_W-1:0] i_fetch_addr,
   output logic              o_instr_valid,
   input  logic              i_instr_ready,
   output logic [DATA_W-1:0] o_instr,
   output logic              o_fault,
   input  logic              i_load_en,
   input  logic              i_load_we,
   input  logic [ADDR_W-1:0] i_load_addr,
   input  logic [DATA_W-1:0] i_load_data,
   output logic              o_load_err
);

   localparam int IDX_W  = ADDR_W - 1;
   localparam int RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATA_W-1:0] mem [0:DEPTH-1];

   logic [IDX_W-1:0]  fetch_idx;
   logic [IDX_W-1:0]  load_idx;
   logic              fetch_ok;
   logic              load_ok;
   logic              fetch_acc;
   logic              load_wr;

   logic              valid_q;
   logic              fault_q;
   logic              nop_q;     // output shows NOP_INSTR instead of RAM data (reset or fault)
   logic              load_err_q;
   logic [DATA_W-1:0] ram_q;

   // Full index is compared against DEPTH so high address bits never alias
   // onto a valid word.
   assign fetch_idx = i_fetch_addr[ADDR_W-1:1];
   assign load_idx  = i_load_addr[ADDR_W-1:1];
   assign fetch_ok  = !i_fetch_addr[0] && (fetch_idx < IDX_W'(DEPTH));
   assign load_ok   = !i_load_addr[0]  && (load_idx  < IDX_W'(DEPTH));

   assign o_fetch_ready = i_rst_n && !i_load_en && (!valid_q || i_instr_ready);
   assign fetch_acc     = i_fetch_valid && o_fetch_ready;
   assign load_wr       = i_rst_n && i_load_en && i_load_we && load_ok;

   // Array and read register carry no reset so the storage maps onto block RAM.
   // Reads and writes never coincide: fetch is blocked while i_load_en is high.
   always_ff @(posedge i_clk) begin
      if (load_wr) begin
         mem[load_idx[RAM_AW-1:0]] <= i_load_data;
      end
      if (fetch_acc && fetch_ok) begin
         ram_q <= mem[fetch_idx[RAM_AW-1:0]];
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         valid_q    <= 1'b0;
         fault_q    <= 1'b0;
         nop_q      <= 1'b1;
         load_err_q <= 1'b0;
      end else begin
         if (fetch_acc) begin
            valid_q <= 1'b1;
            fault_q <= !fetch_ok;
            nop_q   <= !fetch_ok;
         end else if (valid_q && i_instr_ready) begin
            valid_q <= 1'b0;
         end
         load_err_q <= i_load_en && i_load_we && !load_ok;
      end
   end

   assign o_instr_valid = valid_q;
   assign o_fault       = fault_q;
   assign o_instr       = nop_q ? NOP_INSTR : ram_q;
   assign o_load_err    = load_err_q;

endmodule

// File: tb/tb_z16_instr_mem_sync.sv
module tb_z16_instr_mem_sync;

   localparam int DEPTH = 1024;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        fetch_valid;
   logic        fetch_ready;
   logic [15:0] fetch_addr;
   logic        instr_valid;
   logic        instr_ready;
   logic [15:0] instr;
   logic        fault;
   logic        load_en;
   logic        load_we;
   logic [15:0] load_addr;
   logic [15:0] load_data;
   logic        load_err;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   z16_instr_mem_sync #(
      .DATA_W(16), .ADDR_W(16), .DEPTH(DEPTH), .NOP_INSTR(16'h0000)
   ) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_fetch_valid(fetch_valid), .o_fetch_ready(fetch_ready), .i_fetch_addr(fetch_addr),
      .o_instr_valid(instr_valid), .i_instr_ready(instr_ready),
      .o_instr(instr), .o_fault(fault),
      .i_load_en(load_en), .i_load_we(load_we), .i_load_addr(load_addr),
      .i_load_data(load_data), .o_load_err(load_err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // ---------------- transaction-level model ----------------
   logic [15:0] mm [0:DEPTH-1];
   logic        m_valid = 1'b0;
   logic [15:0] m_instr = 16'h0000;
   logic        m_fault = 1'b0;
   logic        m_err   = 1'b0;
   logic        m_after_rst = 1'b0;
   logic        started = 1'b0;

   function automatic logic addr_ok(input logic [15:0] a);
      return (a[0] == 1'b0) && (int'(a >> 1) < DEPTH);
   endfunction

   always @(posedge clk) begin
      logic rdy;
      started = 1'b1;
      if (!rst_n) begin
         m_valid = 1'b0; m_instr = 16'h0000; m_fault = 1'b0; m_err = 1'b0;
         m_after_rst = 1'b1;
      end else begin
         rdy = !load_en && (!m_valid || instr_ready);
         if (fetch_valid && rdy) begin
            m_valid = 1'b1;
            m_after_rst = 1'b0;
            if (addr_ok(fetch_addr)) begin
               m_instr = mm[int'(fetch_addr >> 1)];
               m_fault = 1'b0;
            end else begin
               m_instr = 16'h0000;
               m_fault = 1'b1;
            end
         end else if (m_valid && instr_ready) begin
            m_valid = 1'b0;
         end
         m_err = load_en && load_we && !addr_ok(load_addr);
         if (load_en && load_we && addr_ok(load_addr))
            mm[int'(load_addr >> 1)] = load_data;
      end
   end

   // Compare every cycle on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (started) begin
         chk("instr_valid", 32'(instr_valid), 32'(m_valid));
         chk("load_err", 32'(load_err), 32'(m_err));
         chk("fetch_ready", 32'(fetch_ready),
             32'(rst_n && !load_en && (!m_valid || instr_ready)));
         if (m_valid || m_after_rst) begin
            chk("instr", 32'(instr), 32'(m_instr));
            chk("fault", 32'(fault), 32'(m_fault));
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [15:0] a, input logic [15:0] d);
      load_en = 1'b1; load_we = 1'b1; load_addr = a; load_data = d;
      tick();
   endtask

   task automatic fetch1(input logic [15:0] a);
      fetch_valid = 1'b1; fetch_addr = a;
      tick();
      fetch_valid = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; fetch_valid = 1'b1; fetch_addr = 16'h0000; instr_ready = 1'b1;
      load_en = 1'b0; load_we = 1'b0; load_addr = '0; load_data = '0;

      // reset / idle
      repeat (3) tick();
      chk("rst_valid", 32'(instr_valid), 32'h0);
      chk("rst_instr", 32'(instr), 32'h0);
      chk("rst_fault", 32'(fault), 32'h0);
      chk("rst_err", 32'(load_err), 32'h0);
      chk("rst_ready", 32'(fetch_ready), 32'h0);
      rst_n = 1'b1; fetch_valid = 1'b0;
      tick();

      // load program
      load(16'h0000, 16'h0040);
      load(16'h0002, 16'h605D);
      load(16'h0004, 16'h0000);
      load(16'h0008, 16'h006C);
      load_en = 1'b0; load_we = 1'b0;

      // back-to-back stream
      fetch_valid = 1'b1; fetch_addr = 16'h0000; tick();
      chk("s0_instr", 32'(instr), 32'h0040);
      chk("s0_valid", 32'(instr_valid), 32'h1);
      fetch_addr = 16'h0002; tick();
      chk("s1_instr", 32'(instr), 32'h605D);
      fetch_addr = 16'h0008; tick();
      chk("s2_instr", 32'(instr), 32'h006C);
      chk("s2_fault", 32'(fault), 32'h0);
      fetch_valid = 1'b0; tick();
      chk("s_retire", 32'(instr_valid), 32'h0);

      // backpressure
      instr_ready = 1'b0;
      fetch_valid = 1'b1; fetch_addr = 16'h0002; tick();
      fetch_addr = 16'h0004;
      for (int i = 0; i < 4; i++) begin
         chk("bp_instr", 32'(instr), 32'h605D);
         chk("bp_ready", 32'(fetch_ready), 32'h0);
         tick();
      end
      instr_ready = 1'b1; #1;
      chk("bp_release_ready", 32'(fetch_ready), 32'h1);
      tick();
      chk("bp_next_valid", 32'(instr_valid), 32'h1);
      chk("bp_next_instr", 32'(instr), 32'h0000);
      chk("bp_next_fault", 32'(fault), 32'h0);
      fetch_valid = 1'b0; tick();

      // faults
      fetch1(16'h0003);
      chk("mis_fault", 32'(fault), 32'h1);
      chk("mis_instr", 32'(instr), 32'h0000);
      fetch1(16'h0800);
      chk("oor_fault", 32'(fault), 32'h1);
      tick();

      // rejected loads
      load(16'h0005, 16'hBEEF);
      chk("lerr_pulse", 32'(load_err), 32'h1);
      load_we = 1'b0; tick();
      chk("lerr_clear", 32'(load_err), 32'h0);
      load(16'h0802, 16'hDEAD);        // would alias word 1 if high bits wrapped
      chk("lerr_oor", 32'(load_err), 32'h1);
      load_en = 1'b0; load_we = 1'b0;
      load_we = 1'b1; load_addr = 16'h0003; tick();  // we without en: ignored
      chk("we_no_en", 32'(load_err), 32'h0);
      load_we = 1'b0;
      fetch1(16'h0004);
      chk("post_err_4", 32'(instr), 32'h0000);
      chk("post_err_4f", 32'(fault), 32'h0);
      fetch1(16'h0002);
      chk("no_alias", 32'(instr), 32'h605D);
      tick();

      // load blocking with a pending response
      instr_ready = 1'b0;
      fetch1(16'h0000);
      chk("lb_pending", 32'(instr), 32'h0040);
      load_en = 1'b1; load_we = 1'b1; load_addr = 16'h000A; load_data = 16'h1234;
      fetch_valid = 1'b1; fetch_addr = 16'h000A; instr_ready = 1'b1; #1;
      chk("lb_ready0", 32'(fetch_ready), 32'h0);
      tick();
      chk("lb_drained", 32'(instr_valid), 32'h0);
      load_we = 1'b0; tick();
      chk("lb_ready1", 32'(fetch_ready), 32'h0);
      load_en = 1'b0; #1;
      chk("lb_ready2", 32'(fetch_ready), 32'h1);
      tick();
      chk("lb_new_word", 32'(instr), 32'h1234);
      fetch_valid = 1'b0; tick();

      // mid-operation reset
      instr_ready = 1'b0;
      fetch1(16'h0008);
      chk("mr_pending", 32'(instr), 32'h006C);
      rst_n = 1'b0; tick();
      chk("mr_valid", 32'(instr_valid), 32'h0);
      chk("mr_instr", 32'(instr), 32'h0000);
      rst_n = 1'b1; instr_ready = 1'b1;
      fetch1(16'h0000);
      chk("mr_refetch", 32'(instr), 32'h0040);
      tick();
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
